// File: rtl/out_byte_serializer.sv
// Output byte serializer: buffers 64-bit words from main in a small FIFO and
// streams them MSB byte first over an 8-bit isReady/canReceive link.
module out_byte_serializer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in,
    input  logic             in_isReady,
    output logic             in_canReceive,
    output logic [7:0]       out,
    output logic             out_isReady,
    input  logic             out_canReceive,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

    logic [63:0]       mem_q [DEPTH];
    ptr_t              wr_ptr_q;
    ptr_t              rd_ptr_q;
    logic [FCNT_W-1:0] fifo_cnt_q;
    logic [63:0]       sh_q;
    logic [2:0]        bi_q;
    logic              sv_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic byte_xfer;
    logic word_done;
    logic load;

    // Handshake strobes; acceptance depends only on registered FIFO occupancy.
    always_comb begin
        fifo_full  = (fifo_cnt_q == FCNT_W'(DEPTH));
        fifo_empty = (fifo_cnt_q == '0);
        push       = in_isReady & ~fifo_full;
        byte_xfer  = sv_q & out_canReceive;
        word_done  = byte_xfer & (bi_q == 3'd7);
        // Refill the shifter when idle, or on the last byte for gapless streaming.
        load       = ~fifo_empty & (~sv_q | word_done);
    end

    // FIFO storage; contents are only read while the occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    // FIFO pointers, shifter, byte index and word counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            sh_q       <= '0;
            bi_q       <= '0;
            sv_q       <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_t'(1);
            end
            if (load) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_t'(1);
            end
            case ({push, load})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (load) begin
                sh_q <= mem_q[rd_ptr_q];
                bi_q <= 3'd0;
                sv_q <= 1'b1;
            end else if (byte_xfer) begin
                sh_q <= {sh_q[55:0], 8'h00};
                bi_q <= bi_q + 3'd1;
                if (word_done) begin
                    sv_q <= 1'b0;
                end
            end
            if (word_done) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of stale state.
    always_comb begin
        in_canReceive = rst & ~fifo_full;
        out_isReady   = rst & sv_q;
        out           = (rst && sv_q) ? sh_q[63:56] : 8'h00;
        busy          = rst & (sv_q | ~fifo_empty);
        word_cnt      = rst ? word_cnt_q : '0;
    end

endmodule

// File: tb/tb_out_byte_serializer.sv
// Scoreboard bench for out_byte_serializer: bytes expected are queued when a
// word is accepted and compared when the host side takes a byte.
module tb_out_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in;
    logic        in_isReady;
    logic        in_canReceive;
    logic [7:0]  out;
    logic        out_isReady;
    logic        out_canReceive;
    logic [15:0] word_cnt;
    logic        busy;

    logic        in_canReceive4;
    logic [7:0]  out4;
    logic        out_isReady4;
    logic [3:0]  word_cnt4;
    logic        busy4;

    always #5 clk = ~clk;

    out_byte_serializer #(.DEPTH(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in(in), .in_isReady(in_isReady),
        .in_canReceive(in_canReceive), .out(out), .out_isReady(out_isReady),
        .out_canReceive(out_canReceive), .word_cnt(word_cnt), .busy(busy)
    );

    out_byte_serializer #(.DEPTH(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in(in), .in_isReady(in_isReady),
        .in_canReceive(in_canReceive4), .out(out4), .out_isReady(out_isReady4),
        .out_canReceive(out_canReceive), .word_cnt(word_cnt4), .busy(busy4)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] tx_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_words;
    logic [2:0]  byte_idx;
    logic        hold_prev;
    logic [7:0]  hold_val;
    logic        gap_en;
    logic        gap_arm;
    int unsigned gap_cnt;
    logic [7:0]  eb;
    logic [63:0] w;
    logic [3:0]  pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source driver: offers the head of tx_q until the monitor sees it accepted.
    initial begin
        in         = '0;
        in_isReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_q.size() > 0 && rst) begin
                in         = tx_q[0];
                in_isReady = 1'b1;
            end else begin
                in_isReady = 1'b0;
            end
        end
    end

    // Monitor on the falling edge: predicts transfers at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out", out, 0);
            check("rst_valid", out_isReady, 0);
            check("rst_inrdy", in_canReceive, 0);
            check("rst_busy", busy, 0);
            check("rst_wcnt", word_cnt, 0);
            check("rst_wcnt4", word_cnt4, 0);
            check("rst_misc4", {busy4, in_canReceive4, out_isReady4}, 0);
            exp_q.delete();
            exp_words = '0;
            byte_idx  = '0;
            hold_prev = 1'b0;
        end else begin
            check("word_cnt", word_cnt, exp_words);
            check("word_cnt4", word_cnt4, exp_words[3:0]);
            if (hold_prev) begin
                check("hold_out", out, hold_val);
                check("hold_valid", out_isReady, 1);
            end
            hold_prev = out_isReady && !out_canReceive;
            hold_val  = out;
            if (gap_en && gap_arm && !out_isReady && exp_q.size() > 0) gap_cnt++;
            if (out_isReady && out_canReceive) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", {56'h0, out}, 64'h100);
                end else begin
                    eb = exp_q.pop_front();
                    check("byte", out, eb);
                    check("byte4", out4, eb);
                end
                if (gap_en) gap_arm = 1'b1;
                if (byte_idx == 3'd7) exp_words = exp_words + 16'd1;
                byte_idx = byte_idx + 3'd1;
            end
            if (in_isReady && in_canReceive && tx_q.size() > 0) begin
                w = tx_q.pop_front();
                for (int i = 0; i < 8; i++) exp_q.push_back(w[63 - 8*i -: 8]);
            end
        end
    end

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0 || busy) && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= limit) check("timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int k;
        rst            = 1'b0;
        out_canReceive = 1'b0;
        exp_words      = '0;
        byte_idx       = '0;
        hold_prev      = 1'b0;
        hold_val       = '0;
        gap_en         = 1'b0;
        gap_arm        = 1'b0;
        gap_cnt        = 0;
        pat            = 4'b1001;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word and first-byte latency
        out_canReceive = 1'b1;
        tx_q.push_back(64'h0123456789ABCDEF);
        k = 0;
        while (tx_q.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (k >= 20) check("t1_accept_timeout", 0, 1);
        @(negedge clk);
        check("t1_lat_n", out_isReady, 0);
        @(negedge clk);
        check("t1_lat_n1", out_isReady, 1);
        check("t1_first", out, 8'h01);
        wait_idle(50);
        check("t1_valid_end", out_isReady, 0);
        check("t1_busy_end", busy, 0);
        check("t1_words", word_cnt, 1);

        // Backpressure pattern 1,0,0,1
        tx_q.push_back(64'h0123456789ABCDEF);
        for (int j = 0; j < 200; j++) begin
            if (!(tx_q.size() > 0 || exp_q.size() > 0 || busy)) break;
            out_canReceive = pat[j % 4];
            @(posedge clk);
            #1;
        end
        check("t2_busy_end", busy, 0);
        check("t2_words", word_cnt, 2);

        // Full: three words fit, the fourth stalls
        out_canReceive = 1'b0;
        tx_q.push_back(64'hA0A1A2A3A4A5A6A7);
        tx_q.push_back(64'hB0B1B2B3B4B5B6B7);
        tx_q.push_back(64'hC0C1C2C3C4C5C6C7);
        tx_q.push_back(64'hD0D1D2D3D4D5D6D7);
        repeat (10) @(posedge clk);
        #1;
        check("t3_stalled", tx_q.size(), 1);
        check("t3_inrdy_full", in_canReceive, 0);
        check("t3_busy", busy, 1);
        check("t3_head", out, 8'hA0);
        out_canReceive = 1'b1;
        k = 0;
        while (exp_words != 16'd3 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (k >= 20) check("t3_drain_timeout", 0, 1);
        @(negedge clk);
        check("t3_inrdy_free", in_canReceive, 1);
        check("t3_next_word", out, 8'hB0);
        @(posedge clk);
        #1;
        check("t3_w3_accepted", tx_q.size(), 0);
        wait_idle(100);
        check("t3_words", word_cnt, 6);

        // Gapless sustained stream
        gap_en  = 1'b1;
        gap_arm = 1'b0;
        gap_cnt = 0;
        for (int j = 0; j < 2688; j++) tx_q.push_back({$urandom(), $urandom()});
        wait_idle(30000);
        gap_en = 1'b0;
        check("t4_gaps", gap_cnt, 0);
        check("t4_words", word_cnt, 2694);

        // Reset after three bytes of a word
        tx_q.push_back(64'h1122334455667788);
        k = 0;
        while (!(tx_q.size() == 0 && exp_q.size() == 5) && k < 30) begin
            @(posedge clk);
            k++;
        end
        if (k >= 30) check("t5_bytes_timeout", 0, 1);
        do_reset();
        @(negedge clk);
        check("t5_busy_after", busy, 0);
        check("t5_valid_after", out_isReady, 0);
        tx_q.push_back(64'hFFEEDDCCBBAA9988);
        wait_idle(50);
        repeat (4) @(posedge clk);
        #1;
        check("t5_words", word_cnt, 1);

        // Counter wrap at CNT_W=4
        do_reset();
        for (int j = 0; j < 17; j++) tx_q.push_back({$urandom(), $urandom()});
        wait_idle(500);
        check("t6_wrap4", word_cnt4, 1);
        check("t6_words16", word_cnt, 17);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
